// File: rtl/mul_pkg.sv
// Shared encodings for the sequential multiply controller: op codes, FSM states
// and the default datapath latency.
package mul_pkg;

   localparam int LAT_DEFAULT = 2;

   typedef enum logic [1:0] {
      OP_MUL_W   = 2'b00,
      OP_MULH_W  = 2'b01,
      OP_MULH_WU = 2'b10,
      OP_RSVD    = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } mul_state_e;

   // The reserved encoding runs unsigned and returns the low word.
   function automatic logic op_is_signed(input mul_op_e op);
      return (op == OP_MUL_W) || (op == OP_MULH_W);
   endfunction

   function automatic logic op_sel_high(input mul_op_e op);
      return (op == OP_MULH_W) || (op == OP_MULH_WU);
   endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for a pipelined Booth multiplier: registers operands,
// paces the datapath for LAT cycles and holds the selected result until taken.
//
// state | meaning
// IDLE  | ready for a new request
// CALC  | datapath advancing, cnt counts cycles since operand load
// DONE  | result word held, resp_valid high until consumed
module mul_seq_ctrl
   import mul_pkg::*;
#(
   parameter int LAT = LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   input  logic        flush,
   output logic [31:0] mul_x,
   output logic [31:0] mul_y,
   output logic        mul_signed,
   output logic        mul_stage_en,
   input  logic [63:0] mul_prod,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        busy
);

   localparam logic [2:0] CNT_LAST = 3'(LAT - 1);

   mul_state_e  state_q, state_d;
   mul_op_e     op_q;
   logic [2:0]  cnt_q;
   logic [31:0] result_q;
   logic        accept;
   logic        cnt_done;

   assign accept   = req_valid && req_ready;
   assign cnt_done = (cnt_q == CNT_LAST);

   always_comb begin
      state_d      = state_q;
      req_ready    = (state_q == ST_IDLE) && !flush;
      mul_stage_en = (state_q == ST_CALC);
      resp_valid   = (state_q == ST_DONE);
      busy         = (state_q != ST_IDLE);
      resp_result  = result_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_CALC;
         ST_CALC: if (cnt_done) state_d = ST_DONE;
         ST_DONE: if (resp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // A cancel wins over every transition, including a coincident handshake.
      if (flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_MUL_W;
         cnt_q      <= '0;
         mul_x      <= '0;
         mul_y      <= '0;
         mul_signed <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            mul_x      <= req_src1;
            mul_y      <= req_src2;
            mul_signed <= op_is_signed(mul_op_e'(req_op));
            op_q       <= mul_op_e'(req_op);
            cnt_q      <= '0;
         end else if (state_q == ST_CALC) begin
            cnt_q <= cnt_q + 3'd1;
         end
         if ((state_q == ST_CALC) && cnt_done) begin
            result_q <= op_sel_high(op_q) ? mul_prod[63:32] : mul_prod[31:0];
         end
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: pipelined product stub, directed corner sequences and
// randomized traffic scored against an arithmetic reference model.
module tb_mul_seq_ctrl;
   import mul_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] req_src1 = '0;
   logic [31:0] req_src2 = '0;
   logic        flush = 1'b0;
   logic [31:0] mul_x, mul_y;
   logic        mul_signed, mul_stage_en;
   logic [63:0] mul_prod;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_result;
   logic        busy;

   mul_seq_ctrl #(.LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
      .mul_x(mul_x), .mul_y(mul_y), .mul_signed(mul_signed),
      .mul_stage_en(mul_stage_en), .mul_prod(mul_prod),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] prod_of(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint sa, sb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      return 64'(sa * sb);
   endfunction

   // Datapath stub: LAT-1 enabled register stages behind the operand registers.
   logic [63:0] prod_comb;
   logic [63:0] stg [0:6];
   assign prod_comb = prod_of(mul_x, mul_y, mul_signed);
   always @(posedge clk) begin
      if (mul_stage_en) begin
         stg[0] <= prod_comb;
         for (int i = 1; i < 7; i++) stg[i] <= stg[i-1];
      end
   end
   assign mul_prod = (LAT == 1) ? prod_comb : stg[(LAT > 1) ? LAT - 2 : 0];

   // Reference: the architectural result of each op.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] p;
      p = prod_of(a, b, (op == 2'b00) || (op == 2'b01));
      return ((op == 2'b01) || (op == 2'b10)) ? p[63:32] : p[31:0];
   endfunction

   typedef struct {
      logic [31:0] res;
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;
   logic [31:0] m_x = '0;
   logic [31:0] m_y = '0;
   logic        m_sig = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor and scoreboard: checks at the falling edge, then records acceptance.
   always begin
      bit inflight, exp_valid;
      @(negedge clk);
      if (chk_en) begin
         inflight  = (q.size() != 0);
         exp_valid = inflight && (cyc >= q[0].acc + LAT + 1);
         check("busy", 64'(busy), 64'(inflight));
         check("req_ready", 64'(req_ready), 64'(!inflight && !flush));
         check("resp_valid", 64'(resp_valid), 64'(exp_valid));
         check("mul_stage_en", 64'(mul_stage_en), 64'(inflight && !exp_valid));
         check("mul_x", 64'(mul_x), 64'(m_x));
         check("mul_y", 64'(mul_y), 64'(m_y));
         check("mul_signed", 64'(mul_signed), 64'(m_sig));
         if (exp_valid) check("resp_result", 64'(resp_result), 64'(q[0].res));
         if (reset) begin
            q.delete();
            m_x = '0; m_y = '0; m_sig = 1'b0;
         end else if (inflight && ((exp_valid && resp_ready) || flush)) begin
            void'(q.pop_front());
         end
         #1;
         if (!reset && req_valid && req_ready) begin
            q.push_back('{res: ref_result(req_op, req_src1, req_src2), acc: cyc});
            m_x   = req_src1;
            m_y   = req_src2;
            m_sig = (req_op == 2'b00) || (req_op == 2'b01);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds the request until accepted; returns one cycle later with req_valid still high.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int acc);
      req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
      acc = -1;
      for (int i = 0; i < 40 && acc < 0; i++) begin
         @(negedge clk);
         #2;
         if (req_ready && !reset) acc = cyc;
      end
      if (acc < 0) check("accept_timeout", 64'd0, 64'd1);
      step();
   endtask

   task automatic wait_valid(output int vc);
      vc = -1;
      for (int i = 0; i < 20 && vc < 0; i++) begin
         @(negedge clk);
         if (resp_valid) vc = cyc;
      end
      if (vc < 0) check("valid_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int acc, acc2, vc, hs;
      repeat (3) step();
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_result", 64'(resp_result), 64'd0);
      check("rst_mul_x", 64'(mul_x), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      step();

      // MUL_W latency and signed mode
      resp_ready = 1'b1;
      issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, acc);
      req_valid = 1'b0;
      @(negedge clk);
      check("mulw_signed", 64'(mul_signed), 64'd1);
      wait_valid(vc);
      check("mulw_latency", 64'(vc - acc), 64'd3);
      check("mulw_result", 64'(resp_result), 64'hFFFF_FFFE);
      step();

      // MULH_W and MULH_WU corners
      issue(2'b01, 32'h8000_0000, 32'h8000_0000, acc);
      req_valid = 1'b0;
      wait_valid(vc);
      check("mulhw_result", 64'(resp_result), 64'h4000_0000);
      step();
      issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
      req_valid = 1'b0;
      @(negedge clk);
      check("mulhwu_signed", 64'(mul_signed), 64'd0);
      wait_valid(vc);
      check("mulhwu_result", 64'(resp_result), 64'hFFFF_FFFE);
      step();

      // Consumer stall in DONE with the next request waiting
      resp_ready = 1'b0;
      issue(2'b00, 32'd5, 32'd6, acc);
      req_src1 = 32'd7; req_src2 = 32'd8;
      wait_valid(vc);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", 64'(resp_valid), 64'd1);
         check("stall_result", 64'(resp_result), 64'd30);
         check("stall_req_ready", 64'(req_ready), 64'd0);
         check("stall_busy", 64'(busy), 64'd1);
      end
      step();
      resp_ready = 1'b1;
      hs = cyc;
      issue(2'b00, 32'd7, 32'd8, acc2);
      req_valid = 1'b0;
      check("stall_next_accept", 64'(acc2 - hs), 64'd1);
      wait_valid(vc);
      check("stall_next_result", 64'(resp_result), 64'd56);
      step();

      // Flush in the first CALC cycle
      issue(2'b00, 32'd9, 32'd9, acc);
      req_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("flush_no_valid", 64'(resp_valid), 64'd0);
      end
      step();
      issue(2'b00, 32'd3, 32'd7, acc);
      req_valid = 1'b0;
      wait_valid(vc);
      check("after_flush_result", 64'(resp_result), 64'd21);
      step();

      // Back-to-back with req_valid held
      issue(2'b00, 32'd11, 32'd13, acc);
      req_src1 = 32'd17; req_src2 = 32'd19;
      issue(2'b00, 32'd17, 32'd19, acc2);
      req_valid = 1'b0;
      check("b2b_accept_gap", 64'(acc2 - acc), 64'd4);
      wait_valid(vc);
      check("b2b_second_valid", 64'(vc - acc2), 64'd3);
      check("b2b_second_result", 64'(resp_result), 64'd323);
      step();

      // Reset while DONE
      resp_ready = 1'b0;
      issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, acc);
      req_valid = 1'b0;
      wait_valid(vc);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rstdone_valid", 64'(resp_valid), 64'd0);
      check("rstdone_busy", 64'(busy), 64'd0);
      check("rstdone_result", 64'(resp_result), 64'd0);
      check("rstdone_mul_y", 64'(mul_y), 64'd0);
      check("rstdone_signed", 64'(mul_signed), 64'd0);
      check("rstdone_stage_en", 64'(mul_stage_en), 64'd0);
      check("rstdone_req_ready", 64'(req_ready), 64'd1);
      step();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         req_valid  = ($urandom_range(0, 2) != 0);
         req_op     = 2'($urandom_range(0, 3));
         req_src1   = pick();
         req_src2   = pick();
         resp_ready = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 24) == 0);
         reset      = ($urandom_range(0, 99) == 0);
         step();
      end
      req_valid = 1'b0; flush = 1'b0; reset = 1'b0; resp_ready = 1'b1;
      repeat (12) step();
      @(negedge clk);
      check("drain_empty", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning cycles from operand-register update to valid mul_prod; legal range 1..7.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  EX stage presents a multiply.
REQ-005 SHALL have port req_ready  output  1  controller accepts the request this cycle.
REQ-006 SHALL have port req_op  input  2  00 MUL_W, 01 MULH_W, 10 MULH_WU, 11 reserved.
REQ-007 SHALL have ports req_src1, req_src2  input  32 each  multiplicand and multiplier.
REQ-008 SHALL have port flush  input  1  pipeline cancel from exception or branch.
REQ-009 SHALL have ports mul_x, mul_y  output  32 each  registered operands to the Booth datapath.
REQ-010 SHALL have port mul_signed  output  1  datapath mode: 1 signed, 0 unsigned.
REQ-011 SHALL have port mul_stage_en  output  1  advance enable for datapath pipeline registers.
REQ-012 SHALL have port mul_prod  input  64  full product returned by the datapath.
REQ-013 SHALL have port resp_valid  output  1  result available.
REQ-014 SHALL have port resp_ready  input  1  consumer takes the result.
REQ-015 SHALL have port resp_result  output  32  selected result word.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, CALC and DONE, one operation in flight.
REQ-018 SHALL drive req_ready = (state==IDLE) && !flush.
REQ-019 SHALL, on req_valid && req_ready at cycle T, register src1/src2 to mul_x/mul_y, set mul_signed and latch op, clear cnt and enter CALC at T+1.
REQ-020 SHALL set mul_signed=1 for MUL_W and MULH_W, and mul_signed=0 for MULH_WU and reserved 11.
REQ-021 SHALL hold mul_stage_en=1 only in CALC; cnt increments each CALC cycle.
REQ-022 SHALL, in CALC with cnt==LAT-1 (cycle T+LAT), capture the result word and enter DONE.
REQ-023 SHALL select mul_prod[31:0] for MUL_W and reserved 11, and mul_prod[63:32] for MULH_W and MULH_WU.
REQ-024 SHALL assert resp_valid in DONE only, first at T+LAT+1, with resp_result stable until the handshake.
REQ-025 SHALL go DONE->IDLE on resp_valid && resp_ready; no request is accepted in DONE, giving throughput of one op per LAT+2 cycles.
REQ-026 SHALL, on flush in any state, go to IDLE next cycle with resp_valid low and no response produced; a response handshake coinciding with flush counts as consumed.
REQ-027 SHALL hold mul_x, mul_y and mul_signed unchanged outside acceptance cycles.

Reset
REQ-028 SHALL, on reset, set state=IDLE, cnt=0, mul_x=mul_y=0, mul_signed=0, resp_result=0, resp_valid=0, busy=0, mul_stage_en=0; reset overrides flush and handshakes in the same cycle.

Structure
REQ-029 SHALL take op encodings, state encoding and the default LAT from the shared package mul_pkg.
REQ-030 SHALL be a single module with no sub-module; the Booth and compression datapath is instantiated beside it at the execute-unit level.

Verification
REQ-031 SHALL cover: LAT=2, MUL_W 0xFFFFFFFF*0x00000002 accepted cycle 0 -> mul_signed=1, resp_valid at cycle 3, resp_result 0xFFFFFFFE.
REQ-032 SHALL cover: MULH_W 0x80000000*0x80000000 -> 0x40000000; MULH_WU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE with mul_signed=0.
REQ-033 SHALL cover: resp_ready low 5 cycles in DONE -> resp_valid and resp_result stable, req_ready=0, busy=1; next request accepted the cycle after the handshake.
REQ-034 SHALL cover: flush at the first CALC cycle -> IDLE next cycle, resp_valid never asserted; request 3*7 accepted after that returns 21.
REQ-035 SHALL cover: req_valid held high with two MUL_W ops, LAT=2, resp_ready=1 -> accepts at cycles 0 and 4, resp_valid at cycles 3 and 7.
REQ-036 SHALL cover: reset asserted in DONE -> next cycle all outputs at reset values and req_ready=1.
